// File: rtl/count_down_16_bit.sv
// count_down_16_bit: loadable down-counter / interval timer.
// A start in IDLE loads load_val and counts it down to zero, one step per
// PRESCALE clocks, then emits a one-cycle done pulse and returns to IDLE.
// Optional feature macro: COUNT_DOWN_RELOAD_EN (adds auto_reload input and
// a reload register so the timer can run periodically).
module count_down_16_bit #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
`ifdef COUNT_DOWN_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]      PRE_ZERO = 16'd0;
  localparam logic [15:0]      PRE_ONE  = 16'd1;
  localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [15:0]      r_pre;
  logic [15:0]      w_pre_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_tick;
  logic             w_reload_en;
  logic [WIDTH-1:0] w_reload_val;

`ifdef COUNT_DOWN_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;

  // Periodic mode: reload comes from the value latched at the start edge.
  always_comb begin
    w_reload_en  = auto_reload;
    w_reload_val = r_reload;
  end

  // Reload register: captures load_val only when a run is accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_reload <= CNT_ZERO;
    end else begin
      r_reload <= w_reload_nxt;
    end
  end
`else
  // Single-shot build: periodic reload is never requested.
  always_comb begin
    w_reload_en  = 1'b0;
    w_reload_val = CNT_ZERO;
  end
`endif

  // Prescaler terminal: one decrement tick every PRESCALE clocks.
  always_comb begin
    w_tick = (r_pre == PRE_LAST);
  end

  // Next-state logic; stop outranks start, ticks and terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef COUNT_DOWN_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          if (load_val != CNT_ZERO) begin
            w_count_nxt = load_val;
            w_pre_nxt   = PRE_ZERO;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_RUN;
`ifdef COUNT_DOWN_RELOAD_EN
            w_reload_nxt = load_val;
`endif
          end else begin
            // Zero-length interval: finish immediately without running.
            w_count_nxt = CNT_ZERO;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_pre_nxt   = PRE_ZERO;
        end else if (w_tick) begin
          w_pre_nxt = PRE_ZERO;
          if (r_count > CNT_ONE) begin
            w_count_nxt = r_count - CNT_ONE;
          end else if (w_reload_en) begin
            w_count_nxt = w_reload_val;
            w_done_nxt  = 1'b1;
          end else begin
            // Terminal count (<=1 also guards an unreachable zero).
            w_count_nxt = CNT_ZERO;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_pre_nxt = r_pre + PRE_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_pre_nxt   = PRE_ZERO;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_count <= CNT_ZERO;
      r_pre   <= PRE_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Output drive: registered status, combinational zero flag.
  always_comb begin
    count = r_count;
    busy  = r_busy;
    done  = r_done;
    zero  = (r_count == CNT_ZERO);
  end

endmodule
